u2_serial_conv_ctrl: RTL and testbench

//  Bit-serial sequencer for sign-magnitude to two's-complement (U2) conversion.

---
 rtl/u2_serial_conv_ctrl_if.sv | 30 +++
 rtl/u2_serial_conv_ctrl.sv | 80 ++++++++
 tb/tb_u2_serial_conv_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/u2_serial_conv_ctrl_if.sv
// Operand/result bundle for the bit-serial sign-magnitude to U2 converter.
// Handshake: the source holds start high with sign/mag stable; the block
// accepts it on a rising edge only while busy is low (a start seen while busy
// is dropped, never queued). done pulses for one cycle when result is complete.
// bit_out is meaningful only while bit_valid is high.
interface u2_serial_conv_ctrl_if #(
    parameter int WIDTH = 5
) ();
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] mag;
    logic             busy;
    logic             done;
    logic             bit_out;
    logic             bit_valid;
    logic [WIDTH-1:0] result;
    logic [1:0]       dbg_state;

    // Operand source / consumer side
    modport master (
        output start, sign, mag,
        input  busy, done, bit_out, bit_valid, result, dbg_state
    );

    // Converter side
    modport slave (
        input  start, sign, mag,
        output busy, done, bit_out, bit_valid, result, dbg_state
    );
endinterface

// File: rtl/u2_serial_conv_ctrl.sv
// Bit-serial sign-magnitude to two's-complement converter.
// Walks the latched magnitude LSB-first: bits up to and including the first 1
// are copied, later bits are inverted when the sign flag is set. One bit per
// clock, result bits written in place; result is modulo 2^WIDTH.
module u2_serial_conv_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    u2_serial_conv_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COPY = 2'd1;
    localparam logic [1:0] S_INV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;
    logic             neg;
    logic             b;
    logic             active;
    logic             cur_bit;

    assign b       = shreg[0];
    assign active  = (state == S_COPY) || (state == S_INV);
    // In INV every remaining bit is flipped; in COPY it passes unchanged.
    assign cur_bit = (state == S_INV) ? ~b : b;

    // Sequencer: accept operand, process one bit per cycle, one-cycle DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
            res   <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        shreg <= bus.mag;
                        neg   <= bus.sign;
                        cnt   <= '0;
                        res   <= '0;
                        state <= S_COPY;
                    end
                end
                S_COPY, S_INV: begin
                    res[cnt] <= cur_bit;
                    shreg    <= {1'b0, shreg[WIDTH-1:1]};
                    cnt      <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end else if ((state == S_COPY) && neg && b) begin
                        // First 1 seen on a negative operand: invert from here on.
                        state <= S_INV;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.bit_valid = active;
    assign bus.bit_out   = active ? cur_bit : 1'b0;
    assign bus.result    = res;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_u2_serial_conv_ctrl.sv
// Directed bench for the bit-serial U2 converter with a cycle-level reference
// model and an expected-result queue.
module tb_u2_serial_conv_ctrl;
  localparam int W = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   cmp_en;

  u2_serial_conv_ctrl_if #(.WIDTH(W)) bus ();

  u2_serial_conv_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion straight from the arithmetic definition.
  function automatic logic [W-1:0] conv(input logic s, input logic [W-1:0] m);
    logic [W:0] full;
    full = (1 << W) - {1'b0, m};
    return s ? full[W-1:0] : m;
  endfunction

  // ---------------- reference model ----------------
  // m_phase: 0 idle, 1..W processing bit m_phase-1, W+1 done cycle.
  int             m_phase;
  logic [W-1:0]   m_exp;
  logic [W-1:0]   m_result;
  logic [W-1:0]   exp_q[$];
  logic           bits_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_phase  <= 0;
      m_result <= '0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (bus.start) begin
        m_phase  <= 1;
        m_exp    <= conv(bus.sign, bus.mag);
        m_result <= '0;
        exp_q.push_back(conv(bus.sign, bus.mag));
      end
    end else if (m_phase <= W) begin
      m_result[m_phase-1] <= m_exp[m_phase-1];
      m_phase <= m_phase + 1;
    end else begin
      m_phase <= 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(bus.busy), 32'(m_phase != 0));
      chk("done", 32'(bus.done), 32'(m_phase == W + 1));
      chk("bit_valid", 32'(bus.bit_valid), 32'((m_phase >= 1) && (m_phase <= W)));
      chk("result_track", 32'(bus.result), 32'(m_result));
      if (m_phase >= 1 && m_phase <= W) begin
        chk("bit_out", 32'(bus.bit_out), 32'(m_exp[m_phase-1]));
      end
      if (bus.bit_valid) bits_q.push_back(bus.bit_out);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(1), 32'(0));
        end else begin
          chk("done_result", 32'(bus.result), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic s, input logic [W-1:0] m);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.sign  = s;
    bus.mag   = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sign  = 1'($urandom_range(0, 1));
    bus.mag   = W'($urandom_range(0, (1 << W) - 1));
  endtask

  // Returns number of negedges waited before done was seen (bounded).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_conv(input logic s, input logic [W-1:0] m, input logic [W-1:0] lit);
    int lat;
    bits_q.delete();
    do_start(s, m);
    wait_done(lat);
    chk("latency", 32'(lat), 32'(W));
    chk("result_literal", 32'(bus.result), 32'(lit));
    chk("stream_len", 32'(bits_q.size()), 32'(W));
    for (int i = 0; i < W && i < bits_q.size(); i++) begin
      chk("stream_bit", 32'(bits_q[i]), 32'(lit[i]));
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [W-1:0] hold;
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.mag   = '0;

    // Pin the reference function itself.
    chk("model_neg6", 32'(conv(1'b1, 5'b00110)), 32'(5'b11010));
    chk("model_pos", 32'(conv(1'b0, 5'b10110)), 32'(5'b10110));
    chk("model_neg0", 32'(conv(1'b1, 5'b00000)), 32'(5'b00000));
    chk("model_neg16", 32'(conv(1'b1, 5'b10000)), 32'(5'b10000));
    chk("model_neg1", 32'(conv(1'b1, 5'b00001)), 32'(5'b11111));

    // 1. reset for two cycles then idle
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_bit_valid", 32'(bus.bit_valid), 32'(0));
    chk("rst_bit_out", 32'(bus.bit_out), 32'(0));
    chk("rst_result", 32'(bus.result), 32'(5'b00000));

    // 2. negative operand, stream 0,1,0,1,1
    run_conv(1'b1, 5'b00110, 5'b11010);
    // 3. positive operand stays in copy, same latency
    run_conv(1'b0, 5'b10110, 5'b10110);
    // 4. boundary operands
    run_conv(1'b1, 5'b00000, 5'b00000);
    run_conv(1'b1, 5'b10000, 5'b10000);
    run_conv(1'b1, 5'b00001, 5'b11111);
    run_conv(1'b1, 5'b11111, 5'b00001);
    run_conv(1'b0, 5'b00000, 5'b00000);

    // 5. starts while busy (cycle 2 and DONE) are ignored
    do_start(1'b1, 5'b00110);
    bus.start = 1'b1; bus.sign = 1'b1; bus.mag = 5'b11111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat);
    bus.start = 1'b1; bus.sign = 1'b1; bus.mag = 5'b11111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ignore_busy", 32'(bus.busy), 32'(0));
    chk("ignore_result", 32'(bus.result), 32'(5'b11010));
    run_conv(1'b0, 5'b01011, 5'b01011);

    // 6. reset in the third processing cycle
    do_start(1'b1, 5'b00110);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'(0));
    chk("midrst_result", 32'(bus.result), 32'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(bus.done), 32'(0));
    end
    run_conv(1'b1, 5'b00011, 5'b11101);

    // back-to-back: accept on the first idle cycle after DONE
    hold = 5'b01100;
    do_start(1'b1, hold);
    wait_done(lat);
    bus.start = 1'b1; bus.sign = 1'b0; bus.mag = 5'b10101;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'(1));
    wait_done(lat);
    chk("b2b_result", 32'(bus.result), 32'(5'b10101));
    @(posedge clk); #1;

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
